median_window_3x3: RTL and testbench

Streaming 3x3 neighbourhood generator that sits directly upstream of the 3-input ascending sorters in the median filter datapath. It accepts one pixel per accepted beat in raster order and buffers the two previous image lines. For every pixel that completes a full 3x3 neighbourhood, it emits all nine window pixels in parallel with a valid strobe. Border pixels are never centres: a W x H frame yields exactly (W-2)*(H-2) windows, and no padding is applied.

---
 rtl/median_window_3x3.sv | 79 +++++++
 tb/tb_median_window_3x3.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/median_window_3x3.sv
// Streaming 3x3 neighbourhood generator: two line buffers plus a 3x3 shift window,
// emitting one full window per accepted pixel once two lines and two columns are buffered.
module median_window_3x3 #(
  parameter int DATA_W     = 8,
  parameter int IMG_WIDTH  = 8,
  parameter int IMG_HEIGHT = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_pixel,
  output logic              out_valid,
  output logic [DATA_W-1:0] w00,
  output logic [DATA_W-1:0] w01,
  output logic [DATA_W-1:0] w02,
  output logic [DATA_W-1:0] w10,
  output logic [DATA_W-1:0] w11,
  output logic [DATA_W-1:0] w12,
  output logic [DATA_W-1:0] w20,
  output logic [DATA_W-1:0] w21,
  output logic [DATA_W-1:0] w22,
  output logic              out_eof
);

  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

  logic [CW-1:0] col;
  logic [RW-1:0] row;

  logic [DATA_W-1:0] lb0 [0:IMG_WIDTH-1];
  logic [DATA_W-1:0] lb1 [0:IMG_WIDTH-1];
  logic [DATA_W-1:0] top0;
  logic [DATA_W-1:0] top1;
  logic              emit;

  assign top0 = lb0[col];
  assign top1 = lb1[col];
  assign emit = (row >= RW'(2)) && (col >= CW'(2));

  // Line buffers need no reset; non-blocking writes give read-before-write at the same column.
  always_ff @(posedge clk) begin
    if (rst_n && in_valid) begin
      lb0[col] <= top1;
      lb1[col] <= in_pixel;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      col       <= '0;
      row       <= '0;
      out_valid <= 1'b0;
      out_eof   <= 1'b0;
      w00 <= '0; w01 <= '0; w02 <= '0;
      w10 <= '0; w11 <= '0; w12 <= '0;
      w20 <= '0; w21 <= '0; w22 <= '0;
    end else begin
      out_valid <= 1'b0;
      out_eof   <= 1'b0;
      if (in_valid) begin
        w00 <= w01; w01 <= w02; w02 <= top0;
        w10 <= w11; w11 <= w12; w12 <= top1;
        w20 <= w21; w21 <= w22; w22 <= in_pixel;
        out_valid <= emit;
        out_eof   <= emit && (row == ROW_LAST) && (col == COL_LAST);
        if (col == COL_LAST) begin
          col <= '0;
          row <= (row == ROW_LAST) ? '0 : row + RW'(1);
        end else begin
          col <= col + CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_median_window_3x3.sv
// Scoreboard bench for median_window_3x3: three instances (4x4, 3x3, 8x8) share stimulus,
// an image model predicts each cycle's outputs, and a negedge monitor compares them.
module tb_median_window_3x3;

  typedef struct {
    logic        v;
    logic        e;
    logic [71:0] w;
    bit          chkW;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic [7:0] in_pixel;
  int         sel;

  logic       va, vb, vc;
  logic       ova, ovb, ovc, oea, oeb, oec;
  logic [7:0] wa [9];
  logic [7:0] wb [9];
  logic [7:0] wc [9];

  logic        obsV, obsE;
  logic [71:0] obsW;

  exp_t        q[$];
  logic [7:0]  img [64];
  logic [71:0] lastW;
  bit          wKnown;
  int          mcol, mrow, curW, curH;
  int          nWin, checks, passes;

  always #5 clk = ~clk;

  assign va = in_valid && (sel == 0);
  assign vb = in_valid && (sel == 1);
  assign vc = in_valid && (sel == 2);

  median_window_3x3 #(.DATA_W(8), .IMG_WIDTH(4), .IMG_HEIGHT(4)) u4 (
    .clk(clk), .rst_n(rst_n), .in_valid(va), .in_pixel(in_pixel), .out_valid(ova),
    .w00(wa[0]), .w01(wa[1]), .w02(wa[2]), .w10(wa[3]), .w11(wa[4]), .w12(wa[5]),
    .w20(wa[6]), .w21(wa[7]), .w22(wa[8]), .out_eof(oea));

  median_window_3x3 #(.DATA_W(8), .IMG_WIDTH(3), .IMG_HEIGHT(3)) u3 (
    .clk(clk), .rst_n(rst_n), .in_valid(vb), .in_pixel(in_pixel), .out_valid(ovb),
    .w00(wb[0]), .w01(wb[1]), .w02(wb[2]), .w10(wb[3]), .w11(wb[4]), .w12(wb[5]),
    .w20(wb[6]), .w21(wb[7]), .w22(wb[8]), .out_eof(oeb));

  median_window_3x3 #(.DATA_W(8), .IMG_WIDTH(8), .IMG_HEIGHT(8)) u8 (
    .clk(clk), .rst_n(rst_n), .in_valid(vc), .in_pixel(in_pixel), .out_valid(ovc),
    .w00(wc[0]), .w01(wc[1]), .w02(wc[2]), .w10(wc[3]), .w11(wc[4]), .w12(wc[5]),
    .w20(wc[6]), .w21(wc[7]), .w22(wc[8]), .out_eof(oec));

  always_comb begin
    obsV = ova;
    obsE = oea;
    obsW = {wa[0], wa[1], wa[2], wa[3], wa[4], wa[5], wa[6], wa[7], wa[8]};
    if (sel == 1) begin
      obsV = ovb;
      obsE = oeb;
      obsW = {wb[0], wb[1], wb[2], wb[3], wb[4], wb[5], wb[6], wb[7], wb[8]};
    end else if (sel == 2) begin
      obsV = ovc;
      obsE = oec;
      obsW = {wc[0], wc[1], wc[2], wc[3], wc[4], wc[5], wc[6], wc[7], wc[8]};
    end
  end

  task automatic checkOutput(input string tag, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
  endtask

  // Drive one cycle, then predict what the selected instance shows after that edge.
  task automatic applyStimulus(input logic rst, input logic v, input logic [7:0] p);
    exp_t        e;
    logic [71:0] w;
    rst_n    = rst;
    in_valid = v;
    in_pixel = p;
    @(posedge clk);
    #1;
    e.v = 1'b0; e.e = 1'b0; e.w = lastW; e.chkW = wKnown;
    w = '0;
    if (!rst) begin
      mcol = 0; mrow = 0; lastW = '0; wKnown = 1'b1;
      e.w = '0; e.chkW = 1'b1;
    end else if (v) begin
      img[mrow*curW + mcol] = p;
      if (mrow >= 2 && mcol >= 2) begin
        for (int i = 0; i < 3; i++)
          for (int j = 0; j < 3; j++)
            w[(8 - (i*3 + j))*8 +: 8] = img[(mrow - 2 + i)*curW + (mcol - 2 + j)];
        e.v = 1'b1;
        e.e = (mrow == curH - 1) && (mcol == curW - 1);
        e.w = w; e.chkW = 1'b1;
        lastW = w; wKnown = 1'b1;
      end else begin
        e.chkW = 1'b0; wKnown = 1'b0;
      end
      if (mcol == curW - 1) begin
        mcol = 0;
        mrow = (mrow == curH - 1) ? 0 : mrow + 1;
      end else begin
        mcol++;
      end
    end
    q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      if (obsV === 1'b1) nWin++;
      checkOutput("out_valid", {71'd0, obsV}, {71'd0, e.v});
      checkOutput("out_eof", {71'd0, obsE}, {71'd0, e.e});
      if (e.chkW) checkOutput("window", obsW, e.w);
    end
  end

  task automatic selectDut(input int s, input int w, input int h);
    sel = s; curW = w; curH = h;
    applyStimulus(1'b0, 1'b0, 8'd0);
    nWin = 0;
  endtask

  task automatic finishTest(input string tag, input int expWin);
    applyStimulus(1'b1, 1'b0, 8'd0);
    @(negedge clk);
    #1;
    checkOutput(tag, 72'(nWin), 72'(expWin));
    nWin = 0;
  endtask

  initial begin
    checks = 0; passes = 0; nWin = 0;
    rst_n = 1'b0; in_valid = 1'b0; in_pixel = '0;
    sel = 0; curW = 4; curH = 4; mcol = 0; mrow = 0;
    lastW = '0; wKnown = 1'b1;
    for (int i = 0; i < 64; i++) img[i] = '0;

    selectDut(0, 4, 4);
    for (int i = 0; i < 16; i++) applyStimulus(1'b1, 1'b1, 8'(i));
    finishTest("count_4x4", 4);

    selectDut(0, 4, 4);
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b1, 1'b1, 8'(i));
      applyStimulus(1'b1, 1'b0, 8'hee);
    end
    finishTest("count_gaps", 4);

    selectDut(0, 4, 4);
    for (int i = 0; i < 16; i++) applyStimulus(1'b1, 1'b1, 8'(i));
    for (int i = 0; i < 16; i++) applyStimulus(1'b1, 1'b1, 8'(100 + i));
    finishTest("count_b2b", 8);

    selectDut(0, 4, 4);
    for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b1, 8'(i));
    applyStimulus(1'b0, 1'b1, 8'd77);
    for (int i = 0; i < 16; i++) applyStimulus(1'b1, 1'b1, 8'(i));
    finishTest("count_midreset", 4);

    selectDut(1, 3, 3);
    for (int i = 1; i <= 9; i++) applyStimulus(1'b1, 1'b1, 8'(i));
    finishTest("count_3x3", 1);

    selectDut(2, 8, 8);
    for (int i = 0; i < 64; i++) applyStimulus(1'b1, 1'b1, 8'($urandom_range(0, 255)));
    finishTest("count_8x8", 36);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
